instr_queue: RTL and testbench
==============================

Name: instr_queue

Overview:
- Receive end of the fetch-to-decode interface.
- Buffers fetched pipe_in_t entries (pc, instruction, prediction, branch, jump) in program order and presents the oldest entry to decode/rename.
- Produces the `enable` backpressure that stalls fetch.
- Flushed wholesale on a committed misprediction, in the same cycle fetch receives its redirect pc.

Parameters:
DEPTH, 16, number of entries; must be a power of two, at least 2
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (queue cleared while 0)
push_valid  input  1  fetch presents a valid entry on push_data this cycle
push_data  input  pipe_in_t  entry from fetch (pc[31:0], instruction[31:0], prediction, branch, jump)
enable  output  1  to fetch: queue can accept a push this cycle (= ~full)
pop_valid  output  1  head entry valid for decode
pop_data  output  pipe_in_t  head (oldest) entry
pop_ready  input  1  decode consumes head this cycle
flush  input  1  committed mispredict/redirect: discard all entries
count  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Storage:
  - Circular buffer of DEPTH pipe_in_t entries.
  - Head and tail pointers are PTR_W+1 bits; the MSB is the wrap bit.
  - Empty = pointers fully equal. Full = low bits equal and wrap bits differ.
  - Pointer increment wraps DEPTH-1 -> 0 and toggles the wrap bit.
- Handshakes:
  - Push occurs iff push_valid & enable & ~flush.
  - Pop occurs iff pop_valid & pop_ready & ~flush.
- Outputs:
  - enable = ~full, derived from registered state only; no same-cycle pop bypass, so a full queue rejects a push even when a pop occurs that cycle.
  - pop_valid = ~empty.
  - pop_data = storage[head]: show-ahead, combinational read of registered state.
  - pop_data is don't-care when pop_valid=0; the bench must not check it then.
- Latency:
  - A pushed entry is visible on pop_data/pop_valid the cycle after the push edge (1 cycle).
  - No same-cycle push-to-pop bypass.
- Simultaneous push and pop (queue neither empty nor full): both pointers advance and count is unchanged.
- Push when empty with pop_ready=1: no pop that cycle (pop_valid=0); the entry appears next cycle.
- Flush:
  - Highest priority. At the next edge head=tail=0 (both wrap bits 0) and count=0.
  - Same-cycle push and pop are both ignored.
  - Outputs settle to pop_valid=0, enable=1 after that edge.
  - Storage contents are not cleared.
- Reset:
  - While reset=0: head=0, tail=0, count=0, so pop_valid=0 and enable=1 asynchronously.
  - Reset asserted mid-operation discards all entries immediately.
  - Storage array is not reset.
- count:
  - Registered; +1 on push only, -1 on pop only, unchanged on both or neither, 0 on flush.
  - Never exceeds DEPTH and never underflows.
  - count must always equal tail - head (modulo 2^(PTR_W+1)).
- Decode must treat pop_data fields exactly as produced by fetch. The queue never alters an entry; prediction/branch/jump pass through untouched.
- Assertions (sim-only):
  - No push accepted when full.
  - No pop when empty.
  - count == DEPTH iff full.

Decomposition:
- pipe_in_t stays in the shared structs header alongside the other pipeline typedefs.
- Add IQ_DEPTH (16) to the same header so fetch-side and decode-side logic agree on the depth.
- One natural sub-module: iq_ptr, a (PTR_W+1)-bit wrapping pointer with inc and clr inputs, instantiated twice (head, tail).
- Full/empty compare and storage stay in instr_queue.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, then release -> pop_valid=0, enable=1, count=0; no pop for 5 idle cycles.
- Fill to full: push 16 entries with pc=0x1000+4i, pop_ready=0 -> enable drops to 0 the cycle after the 16th push and count=16. A 17th push_valid is ignored: count stays 16 and the tail does not move.
- Order/drain: from the full state, pop_ready=1 -> pop_data.pc sequence 0x1000, 0x1004, ..., 0x103C, one per cycle. pop_valid falls after the 16th pop; count=0.
- Wrap and concurrency: push/pop continuously for 40 cycles at occupancy 8 -> count stays 8 and pcs emerge strictly in order across the pointer wrap. A push and a pop in the same cycle at occupancy 8 (neither empty nor full) leave count unchanged. At full, push_valid=1 with pop_ready=1 -> pop occurs, push rejected, count goes 16->15.
- Flush mid-stream: occupancy 5, assert flush together with push_valid=1 and pop_ready=1 -> next cycle count=0, pop_valid=0, enable=1. A subsequent push of pc=0x2000 appears at the head one cycle later.
- Async reset mid-operation: occupancy 10, drop reset between clock edges -> pop_valid=0 and count=0 before the next edge. After release, the first pushed pc=0x3000 appears at the head.

Source files
------------

// File: rtl/instr_queue_pkg.sv
// Shared fetch/decode pipeline types: the fetch-to-decode entry and the queue depth
// both sides agree on.
package instr_queue_pkg;

    localparam int IQ_DEPTH = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        prediction;
        logic        branch;
        logic        jump;
    } pipe_in_t;

endpackage

// File: rtl/instr_queue_ptr.sv
// Wrapping queue pointer: low bits index storage, MSB is the wrap bit that
// distinguishes full from empty. Clear has priority over increment.
module iq_ptr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] ptr
);

    localparam logic [W-1:0] ONE = W'(1);

    // DEPTH is a power of two, so plain binary increment wraps the index and
    // toggles the wrap bit in one step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   ptr <= '0;
        else if (clr) ptr <= '0;
        else if (inc) ptr <= ptr + ONE;
    end

endmodule

// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue: in-order circular buffer with show-ahead head,
// full-based backpressure to fetch and single-cycle wholesale flush on redirect.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter  int DEPTH = IQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push_valid,
    input  pipe_in_t       push_data,
    output logic           enable,
    output logic           pop_valid,
    output pipe_in_t       pop_data,
    input  logic           pop_ready,
    input  logic           flush,
    output logic [PTR_W:0] count
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instr_queue: DEPTH must be a power of two >= 2");
    end

    localparam logic [PTR_W:0] ONE = (PTR_W + 1)'(1);

    logic [PTR_W:0] head, tail;
    logic           full, empty, push, pop;
    pipe_in_t       mem [DEPTH];

    assign empty = (head == tail);
    assign full  = (head[PTR_W] != tail[PTR_W]) &&
                   (head[PTR_W-1:0] == tail[PTR_W-1:0]);

    // Backpressure comes from registered state only; a pop in the same cycle
    // does not make room for a push.
    assign enable    = ~full;
    assign pop_valid = ~empty;
    assign pop_data  = mem[head[PTR_W-1:0]];

    assign push = push_valid & enable & ~flush;
    assign pop  = pop_valid & pop_ready & ~flush;

    iq_ptr #(.W(PTR_W + 1)) u_head (
        .clk   (clk),
        .reset (reset),
        .inc   (pop),
        .clr   (flush),
        .ptr   (head)
    );

    iq_ptr #(.W(PTR_W + 1)) u_tail (
        .clk   (clk),
        .reset (reset),
        .inc   (push),
        .clr   (flush),
        .ptr   (tail)
    );

    // Storage is never reset or cleared; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) mem[tail[PTR_W-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)           count <= '0;
        else if (flush)       count <= '0;
        else if (push & ~pop) count <= count + ONE;
        else if (pop & ~push) count <= count - ONE;
    end

    a_no_push_full : assert property (@(posedge clk) disable iff (!reset)
        push |-> !full);
    a_no_pop_empty : assert property (@(posedge clk) disable iff (!reset)
        pop |-> !empty);
    a_count_full : assert property (@(posedge clk) disable iff (!reset)
        (count == (PTR_W + 1)'(DEPTH)) == full);
    a_count_ptrs : assert property (@(posedge clk) disable iff (!reset)
        count == (tail - head));

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: table-driven opening sequence, then a
// scoreboard queue of expected entries checked as decode pops them.
module tb_instr_queue;
    import instr_queue_pkg::*;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       push_valid = 1'b0;
    pipe_in_t   push_data = '0;
    logic       enable;
    logic       pop_valid;
    pipe_in_t   pop_data;
    logic       pop_ready = 1'b0;
    logic       flush = 1'b0;
    logic [4:0] count;

    int n_cmp = 0;
    int n_bad = 0;
    pipe_in_t sb[$];

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push_valid),
        .push_data  (push_data),
        .enable     (enable),
        .pop_valid  (pop_valid),
        .pop_data   (pop_data),
        .pop_ready  (pop_ready),
        .flush      (flush),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic        pr;
        logic        fl;
        int          exp_cnt;
        logic        exp_pv;
        logic        exp_en;
    } vec_t;

    function automatic pipe_in_t mk(input logic [31:0] pc);
        pipe_in_t e;
        e.pc          = pc;
        e.instruction = pc ^ 32'hA5A5_0013;
        e.prediction  = pc[2];
        e.branch      = pc[3];
        e.jump        = pc[4] ^ pc[2];
        return e;
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check against the model, let the edge
    // happen, then return idle at posedge+1.
    task automatic cyc(input logic pv, input logic [31:0] pc, input logic pr, input logic fl);
        int sz;
        @(negedge clk);
        push_valid = pv;
        push_data  = mk(pc);
        pop_ready  = pr;
        flush      = fl;
        #1;
        sz = sb.size();
        chk("count", 96'(count), 96'(sz));
        chk("pop_valid", 96'(pop_valid), 96'(sz != 0));
        chk("enable", 96'(enable), 96'(sz < DEPTH));
        if (sz != 0 && pr && !fl) chk("pop_data", 96'(pop_data), 96'(sb[0]));
        if (fl) sb.delete();
        else begin
            if (sz != 0 && pr) void'(sb.pop_front());
            if (pv && sz < DEPTH) sb.push_back(mk(pc));
        end
        @(posedge clk);
        #1;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        flush      = 1'b0;
    endtask

    vec_t vt[8];

    initial begin
        vt[0] = '{1'b1, 32'h0A0, 1'b0, 1'b0, 0, 1'b0, 1'b1};
        vt[1] = '{1'b1, 32'h0A4, 1'b1, 1'b0, 1, 1'b1, 1'b1};
        vt[2] = '{1'b1, 32'h0A8, 1'b0, 1'b0, 1, 1'b1, 1'b1};
        vt[3] = '{1'b0, 32'h000, 1'b1, 1'b0, 2, 1'b1, 1'b1};
        vt[4] = '{1'b0, 32'h000, 1'b1, 1'b0, 1, 1'b1, 1'b1};
        vt[5] = '{1'b1, 32'h0AC, 1'b1, 1'b0, 0, 1'b0, 1'b1};
        vt[6] = '{1'b0, 32'h000, 1'b0, 1'b1, 1, 1'b1, 1'b1};
        vt[7] = '{1'b0, 32'h000, 1'b1, 1'b0, 0, 1'b0, 1'b1};

        // Reset / idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pop_valid", 96'(pop_valid), 96'(0));
        chk("rst_enable", 96'(enable), 96'(1));
        chk("rst_count", 96'(count), 96'(0));
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Table-driven opening sequence
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("vec%0d_count", i), 96'(count), 96'(vt[i].exp_cnt));
            chk($sformatf("vec%0d_pop_valid", i), 96'(pop_valid), 96'(vt[i].exp_pv));
            chk($sformatf("vec%0d_enable", i), 96'(enable), 96'(vt[i].exp_en));
            cyc(vt[i].pv, vt[i].pc, vt[i].pr, vt[i].fl);
        end

        // Fill to full, then a rejected 17th push
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
        chk("full_enable", 96'(enable), 96'(0));
        chk("full_count", 96'(count), 96'(16));
        cyc(1'b1, 32'hDEAD, 1'b0, 1'b0);
        chk("full_reject_count", 96'(count), 96'(16));

        // Drain in order
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("drain_pc%0d", i), 96'(pop_data.pc), 96'(32'h1000 + 32'(4 * i)));
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
        end
        chk("drain_pop_valid", 96'(pop_valid), 96'(0));
        chk("drain_count", 96'(count), 96'(0));

        // Steady push/pop at occupancy 8 across the pointer wrap
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'h4000 + 32'(4 * i), 1'b0, 1'b0);
        for (int i = 8; i < 48; i++) begin
            cyc(1'b1, 32'h4000 + 32'(4 * i), 1'b1, 1'b0);
            chk("steady_count", 96'(count), 96'(8));
        end

        // Full with push and pop together: pop only
        for (int i = 48; i < 56; i++) cyc(1'b1, 32'h4000 + 32'(4 * i), 1'b0, 1'b0);
        chk("refill_count", 96'(count), 96'(16));
        cyc(1'b1, 32'hBEEF, 1'b1, 1'b0);
        chk("full_pushpop_count", 96'(count), 96'(15));

        // Flush at occupancy 5 with push and pop asserted
        for (int i = 0; i < 10; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("preflush_count", 96'(count), 96'(5));
        cyc(1'b1, 32'h5555, 1'b1, 1'b1);
        chk("flush_count", 96'(count), 96'(0));
        chk("flush_pop_valid", 96'(pop_valid), 96'(0));
        chk("flush_enable", 96'(enable), 96'(1));
        cyc(1'b1, 32'h2000, 1'b0, 1'b0);
        chk("postflush_head", 96'(pop_data.pc), 96'(32'h2000));
        chk("postflush_pop_valid", 96'(pop_valid), 96'(1));
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-operation at occupancy 10
        for (int i = 0; i < 10; i++) cyc(1'b1, 32'h6000 + 32'(4 * i), 1'b0, 1'b0);
        chk("prereset_count", 96'(count), 96'(10));
        #2 reset = 1'b0;
        #1;
        chk("async_pop_valid", 96'(pop_valid), 96'(0));
        chk("async_count", 96'(count), 96'(0));
        chk("async_enable", 96'(enable), 96'(1));
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc(1'b1, 32'h3000, 1'b0, 1'b0);
        chk("postreset_head", 96'(pop_data.pc), 96'(32'h3000));
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("final_count", 96'(count), 96'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
